// File: rtl/vector_result_collector.sv
// Gathers per-lane adder results into one LANES-wide vector and hands it downstream
// over valid/ready, with a partial-vector timeout and sticky protocol error flags.
module vector_result_collector #(
  parameter int unsigned LANES          = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  lane_valid,
  input  logic [DATA_W-1:0] lane_data [LANES-1:0],
  output logic              in_ready,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [DATA_W-1:0] vec_data [LANES-1:0],
  output logic [LANES-1:0]  lane_mask,
  output logic [CNT_W-1:0]  vec_count,
  output logic              dup_err,
  output logic              ovf_err,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned TmoW =
      ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e            state_q, state_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              dup_q, dup_d;
  logic              ovf_q, ovf_d;
  logic              tmo_err_q, tmo_err_d;
  logic [DATA_W-1:0] data_q [LANES-1:0];

  logic [LANES-1:0]  cap;
  logic              dup_ev, ovf_ev, tmo_ev;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    cap     = '0;
    dup_ev  = 1'b0;
    ovf_ev  = 1'b0;
    tmo_ev  = 1'b0;

    unique case (state_q)
      StCollect: begin
        cap    = lane_valid & ~mask_q;
        dup_ev = |(lane_valid & mask_q);
        mask_d = mask_q | cap;
        if (&mask_d) begin
          state_d = StHold;
          tmo_d   = '0;
        end else if (|cap) begin
          tmo_d = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (|mask_q)) begin
          // The idle cycle that would bring the count to TIMEOUT_CYCLES aborts the vector.
          if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            mask_d = '0;
            tmo_d  = '0;
            tmo_ev = 1'b1;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end else begin
          tmo_d = '0;
        end
      end
      StHold: begin
        ovf_ev = |lane_valid;
        tmo_d  = '0;
        if (vec_ready) begin
          state_d = StCollect;
          mask_d  = '0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Clear first so that a coincident error event wins over err_clr.
  always_comb begin
    dup_d     = err_clr ? 1'b0 : dup_q;
    ovf_d     = err_clr ? 1'b0 : ovf_q;
    tmo_err_d = err_clr ? 1'b0 : tmo_err_q;
    if (dup_ev) dup_d = 1'b1;
    if (ovf_ev) ovf_d = 1'b1;
    if (tmo_ev) tmo_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      mask_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      dup_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      dup_q     <= dup_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Lanes not rewritten keep stale data from the previous vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LANES); i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (cap[i]) data_q[i] <= lane_data[i];
      end
    end
  end

  assign in_ready    = (state_q == StCollect);
  assign vec_valid   = (state_q == StHold);
  assign vec_data    = data_q;
  assign lane_mask   = mask_q;
  assign vec_count   = cnt_q;
  assign dup_err     = dup_q;
  assign ovf_err     = ovf_q;
  assign timeout_err = tmo_err_q;

endmodule
